// File: rtl/hazard_pkg.sv
// Shared types, forwarding-select encodings and the forwarding helper
// used by the RV32I 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // The youngest producer (MEM) wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                            input logic [4:0] rd_m,
                                            input logic       wr_m,
                                            input logic [4:0] rd_w,
                                            input logic       wr_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_MEM;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/perf_cnt32.sv
// 32-bit wrapping event counter with asynchronous active-low clear.
module perf_cnt32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (en)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory wait states,
// branch redirects, EX operand forwarding and performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        use_rs1_D,
  input  logic        use_rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic        mem_read_E,
  input  logic        br_taken_E,
  input  logic [4:0]  rd_M,
  input  logic [4:0]  rd_W,
  input  logic        reg_write_M,
  input  logic        reg_write_W,
  input  logic        dmem_req_M,
  input  logic        dmem_ready_M,
  output logic        bubbleF,
  output logic        bubbleD,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic [1:0]  fwd1_E,
  output logic [1:0]  fwd2_E,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirects,
  output logic        mem_timeout
);

  localparam logic [1:0]  LU_LOAD   = 2'(LOAD_USE_STALLS - 1);
  localparam logic [16:0] TIMEOUT_W = 17'(MEM_TIMEOUT);

  hz_state_t   state, state_nxt, eff_state;
  logic [1:0]  lu_cnt, lu_cnt_nxt;
  logic [15:0] wait_cnt;
  logic [16:0] wait_cnt_inc;
  logic        mem_wait, lu_haz, redirect_acc;

  assign mem_wait = dmem_req_M & ~dmem_ready_M;
  assign lu_haz   = mem_read_E & (rd_E != 5'd0) &
                    ((use_rs1_D & (rs1_D == rd_E)) | (use_rs2_D & (rs2_D == rd_E)));

  // The cycle leaving MEM_WAIT behaves as whichever state the wait interrupted.
  assign eff_state = (state == MEM_WAIT) ? ((lu_cnt != 2'd0) ? LU_STALL : RUN) : state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = eff_state;
    lu_cnt_nxt = lu_cnt;
    if (mem_wait) begin
      state_nxt = MEM_WAIT;
    end else if (eff_state == LU_STALL) begin
      lu_cnt_nxt = (lu_cnt != 2'd0) ? (lu_cnt - 2'd1) : 2'd0;
      state_nxt  = (lu_cnt <= 2'd1) ? RUN : LU_STALL;
    end else if (lu_haz) begin
      lu_cnt_nxt = LU_LOAD;
      state_nxt  = (LOAD_USE_STALLS > 1) ? LU_STALL : RUN;
    end
  end

  always_comb begin
    bubbleF      = 1'b0;
    bubbleD      = 1'b0;
    bubbleE      = 1'b0;
    bubbleM      = 1'b0;
    bubbleW      = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    flushM       = 1'b0;
    flushW       = 1'b0;
    redirect_acc = 1'b0;
    if (!rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (mem_wait) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      bubbleE = 1'b1;
      bubbleM = 1'b1;
      flushW  = 1'b1;
    end else if ((eff_state == LU_STALL) || lu_haz) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end else if (br_taken_E) begin
      flushD       = 1'b1;
      flushE       = 1'b1;
      redirect_acc = 1'b1;
    end
  end

  assign fwd1_E = rst_n ? fwd_select(rs1_E, rd_M, reg_write_M, rd_W, reg_write_W) : FWD_RF;
  assign fwd2_E = rst_n ? fwd_select(rs2_E, rd_M, reg_write_M, rd_W, reg_write_W) : FWD_RF;

  // The timeout flag rises on the same edge that wait_cnt reaches the limit.
  assign wait_cnt_inc = {1'b0, wait_cnt} + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt_inc[15:0];
      if (wait_cnt_inc == TIMEOUT_W)
        mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  perf_cnt32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubbleF),
    .count (stall_cycles)
  );

  perf_cnt32 u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect_acc),
    .count (redirects)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two hazard_ctrl instances (1 and 2 load-use bubbles)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MT = 4;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       use_rs1_D, use_rs2_D, mem_read_E, br_taken_E;
    logic       reg_write_M, reg_write_W, dmem_req_M, dmem_ready_M;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic use_rs1_D, use_rs2_D, mem_read_E, br_taken_E;
  logic reg_write_M, reg_write_W, dmem_req_M, dmem_ready_M;

  logic [1:0]  bF, bD, bE, bM, bW, fD, fE, fM, fW, to;
  logic [1:0]  fwd1 [2];
  logic [1:0]  fwd2 [2];
  logic [31:0] stall [2];
  logic [31:0] redir [2];

  int          lus [2] = '{1, 2};
  int          mStalls [2];
  int          mWait [2];
  logic [31:0] mStall [2];
  logic [31:0] mRedir [2];
  logic        mTo [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(MT)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .mem_read_E(mem_read_E), .br_taken_E(br_taken_E),
    .rd_M(rd_M), .rd_W(rd_W), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .bubbleF(bF[0]), .bubbleD(bD[0]), .bubbleE(bE[0]), .bubbleM(bM[0]), .bubbleW(bW[0]),
    .flushD(fD[0]), .flushE(fE[0]), .flushM(fM[0]), .flushW(fW[0]),
    .fwd1_E(fwd1[0]), .fwd2_E(fwd2[0]),
    .stall_cycles(stall[0]), .redirects(redir[0]), .mem_timeout(to[0])
  );

  hazard_ctrl #(.LOAD_USE_STALLS(2), .MEM_TIMEOUT(MT)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .mem_read_E(mem_read_E), .br_taken_E(br_taken_E),
    .rd_M(rd_M), .rd_W(rd_W), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .bubbleF(bF[1]), .bubbleD(bD[1]), .bubbleE(bE[1]), .bubbleM(bM[1]), .bubbleW(bW[1]),
    .flushD(fD[1]), .flushE(fE[1]), .flushM(fM[1]), .flushW(fW[1]),
    .fwd1_E(fwd1[1]), .fwd2_E(fwd2[1]),
    .stall_cycles(stall[1]), .redirects(redir[1]), .mem_timeout(to[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [4:0] rs);
    if (reg_write_M && rd_M != 5'd0 && rd_M == rs) return 2'b01;
    if (reg_write_W && rd_W != 5'd0 && rd_W == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.rst_n = 1'b1;
    s.rs1_D = '0; s.rs2_D = '0; s.rs1_E = '0; s.rs2_E = '0;
    s.rd_E = '0; s.rd_M = '0; s.rd_W = '0;
    s.use_rs1_D = 1'b0; s.use_rs2_D = 1'b0; s.mem_read_E = 1'b0; s.br_taken_E = 1'b0;
    s.reg_write_M = 1'b0; s.reg_write_W = 1'b0; s.dmem_req_M = 1'b0; s.dmem_ready_M = 1'b1;
    return s;
  endfunction

  // Drive one cycle, check every output against the model, then advance the model over the edge.
  task automatic applyStimulus(input stim_t s);
    logic       memWait, luHaz;
    logic [8:0] exp, got;
    logic       acc [2];
    logic       stalled [2];
    rst_n = s.rst_n;
    rs1_D = s.rs1_D; rs2_D = s.rs2_D; rs1_E = s.rs1_E; rs2_E = s.rs2_E;
    rd_E = s.rd_E; rd_M = s.rd_M; rd_W = s.rd_W;
    use_rs1_D = s.use_rs1_D; use_rs2_D = s.use_rs2_D;
    mem_read_E = s.mem_read_E; br_taken_E = s.br_taken_E;
    reg_write_M = s.reg_write_M; reg_write_W = s.reg_write_W;
    dmem_req_M = s.dmem_req_M; dmem_ready_M = s.dmem_ready_M;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mStalls[k] = 0; mWait[k] = 0; mStall[k] = '0; mRedir[k] = '0; mTo[k] = 1'b0;
      end
    end
    #2;
    memWait = dmem_req_M && !dmem_ready_M;
    luHaz   = mem_read_E && rd_E != 5'd0 &&
              ((use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E));
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (!rst_n)                         exp = 9'b00000_1111;
      else if (memWait)                   exp = 9'b11110_0001;
      else if (mStalls[k] > 0 || luHaz)   exp = 9'b11000_0100;
      else if (br_taken_E) begin          exp = 9'b00000_1100; acc[k] = 1'b1; end
      else                                exp = 9'b00000_0000;
      stalled[k] = exp[8];
      got = {bF[k], bD[k], bE[k], bM[k], bW[k], fD[k], fE[k], fM[k], fW[k]};
      checkOutput($sformatf("ctrl%0d", k), 32'(got), 32'(exp));
      checkOutput($sformatf("fwd%0d", k), 32'({fwd1[k], fwd2[k]}),
                  rst_n ? 32'({fwdRef(rs1_E), fwdRef(rs2_E)}) : 32'd0);
      checkOutput($sformatf("stall_cycles%0d", k), stall[k], mStall[k]);
      checkOutput($sformatf("redirects%0d", k), redir[k], mRedir[k]);
      checkOutput($sformatf("mem_timeout%0d", k), 32'(to[k]), 32'(mTo[k]));
    end
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (memWait) begin
          mWait[k]++;
          if (mWait[k] == MT) mTo[k] = 1'b1;
        end else begin
          mWait[k] = 0;
          if (mStalls[k] > 0) mStalls[k]--;
          else if (luHaz) mStalls[k] = lus[k] - 1;
        end
        if (stalled[k]) mStall[k] = mStall[k] + 32'd1;
        if (acc[k]) mRedir[k] = mRedir[k] + 32'd1;
      end
    end
    #1;
  endtask

  task automatic resetCycle();
    stim_t s;
    s = idleStim();
    s.rst_n = 1'b0;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    int burst;
    #1;
    resetCycle();
    resetCycle();

    // Load-use on x5 through rs1
    s = idleStim();
    s.mem_read_E = 1'b1; s.rd_E = 5'd5; s.use_rs1_D = 1'b1; s.rs1_D = 5'd5;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("lu_stalls_1", stall[0], 32'd1);
    checkOutput("lu_stalls_2", stall[1], 32'd2);

    // Load to x0 never stalls
    s.rd_E = 5'd0; s.rs1_D = 5'd0;
    applyStimulus(s);
    checkOutput("lu_x0_stalls", stall[0], 32'd1);

    // Forwarding priority
    s = idleStim();
    s.rd_M = 5'd7; s.rd_W = 5'd7; s.reg_write_M = 1'b1; s.reg_write_W = 1'b1; s.rs1_E = 5'd7;
    applyStimulus(s);
    s.reg_write_M = 1'b0;
    applyStimulus(s);

    // Three-cycle memory wait
    resetCycle();
    s = idleStim();
    s.dmem_req_M = 1'b1; s.dmem_ready_M = 1'b0;
    repeat (3) applyStimulus(s);
    s.dmem_ready_M = 1'b1;
    applyStimulus(s);
    checkOutput("wait_stalls", stall[0], 32'd3);

    // Branch held during a two-cycle wait counts once on exit
    resetCycle();
    s = idleStim();
    s.dmem_req_M = 1'b1; s.dmem_ready_M = 1'b0; s.br_taken_E = 1'b1;
    repeat (2) applyStimulus(s);
    s.dmem_ready_M = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("wait_branch_redirects", redir[0], 32'd1);

    // Timeout after four wait cycles, sticky until reset
    resetCycle();
    s = idleStim();
    s.dmem_req_M = 1'b1; s.dmem_ready_M = 1'b0;
    repeat (6) applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("timeout_sticky", 32'(to[0]), 32'd1);

    // Reset in the middle of a wait
    s = idleStim();
    s.dmem_req_M = 1'b1; s.dmem_ready_M = 1'b0;
    repeat (2) applyStimulus(s);
    resetCycle();
    applyStimulus(idleStim());
    checkOutput("timeout_cleared", 32'(to[0]), 32'd0);

    // Randomised traffic with occasional long waits and resets
    burst = 0;
    repeat (800) begin
      s.rst_n       = ($urandom_range(0, 99) != 0);
      s.rs1_D       = 5'($urandom_range(0, 3));
      s.rs2_D       = 5'($urandom_range(0, 3));
      s.rs1_E       = 5'($urandom_range(0, 3));
      s.rs2_E       = 5'($urandom_range(0, 3));
      s.rd_E        = 5'($urandom_range(0, 3));
      s.rd_M        = 5'($urandom_range(0, 3));
      s.rd_W        = 5'($urandom_range(0, 3));
      s.use_rs1_D   = 1'($urandom_range(0, 1));
      s.use_rs2_D   = 1'($urandom_range(0, 1));
      s.mem_read_E  = ($urandom_range(0, 2) == 0);
      s.br_taken_E  = ($urandom_range(0, 3) == 0);
      s.reg_write_M = 1'($urandom_range(0, 1));
      s.reg_write_W = 1'($urandom_range(0, 1));
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 7);
      if (burst > 0) begin
        s.dmem_req_M = 1'b1; s.dmem_ready_M = 1'b0;
        burst--;
      end else begin
        s.dmem_req_M   = ($urandom_range(0, 2) == 0);
        s.dmem_ready_M = 1'($urandom_range(0, 1));
      end
      applyStimulus(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. Every cycle it drives the per-stage `bubble*` (hold) and `flush*` (clear-to-NOP) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage operand forwarding selects. It sequences load-use stalls, data-memory wait states and branch redirects. It also keeps stall and redirect performance counters and raises a memory-timeout flag.

## Interface
Parameters:
- `LOAD_USE_STALLS`, 1 — bubbles per load-use hazard (1 or 2).
- `MEM_TIMEOUT`, 1024 — wait cycles before `mem_timeout` sets (1..65535).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `rs1_D`, `rs2_D`  in  5  source registers in ID.
- `use_rs1_D`, `use_rs2_D`  in  1  ID instruction reads rs1/rs2.
- `rs1_E`, `rs2_E`, `rd_E`  in  5  EX-stage register fields.
- `mem_read_E`  in  1  EX instruction is a load.
- `br_taken_E`  in  1  branch/JAL/JALR redirect resolved in EX.
- `rd_M`, `rd_W`  in  5  destination registers in MEM/WB.
- `reg_write_M`, `reg_write_W`  in  1  write-enables in MEM/WB.
- `dmem_req_M`, `dmem_ready_M`  in  1  data-memory request/ready.
- `bubbleF`, `bubbleD`, `bubbleE`, `bubbleM`, `bubbleW`  out  1  hold stage register.
- `flushD`, `flushE`, `flushM`, `flushW`  out  1  clear stage register. A flush is effective only when the same stage's bubble is 0.
- `fwd1_E`, `fwd2_E`  out  2  operand select: 00 regfile, 01 MEM result, 10 WB result.
- `stall_cycles`  out  32  cycles with `bubbleF`=1.
- `redirects`  out  32  accepted `br_taken_E` events.
- `mem_timeout`  out  1  sticky error flag.

## Operation
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state: RUN.
- Hazard definitions:
  - `mem_wait` = `dmem_req_M & ~dmem_ready_M`.
  - `lu_haz` = `mem_read_E & rd_E!=0 & ((use_rs1_D & rs1_D==rd_E) | (use_rs2_D & rs2_D==rd_E))`.
- Priority each cycle, highest first:
  1. `mem_wait`: `bubbleF`/`bubbleD`/`bubbleE`/`bubbleM`=1, `flushW`=1, all other flushes 0. Next state MEM_WAIT.
  2. State LU_STALL: `bubbleF`=`bubbleD`=1, `flushE`=1. Decrement `lu_cnt`. When `lu_cnt`=0, return to RUN.
  3. `lu_haz` in RUN: `bubbleF`=`bubbleD`=1, `flushE`=1. Load `lu_cnt`=`LOAD_USE_STALLS`-1. If `LOAD_USE_STALLS`>1, go to LU_STALL.
  4. `br_taken_E`: `flushD`=`flushE`=1; `redirects`++.
  5. Otherwise all outputs 0.
- MEM_WAIT exit: on the first cycle `mem_wait`=0, resume from LU_STALL if `lu_cnt`≠0, else RUN. A `br_taken_E` held in the frozen EX stage is applied on that exit cycle, so it counts exactly once.
- `lu_haz` and `br_taken_E` are mutually exclusive by construction. If both are asserted, `lu_haz` wins.
- Forwarding for `fwdN_E` with source `rsN_E`:
  - 01 if `reg_write_M & rd_M!=0 & rd_M==rsN_E`.
  - Else 10 if `reg_write_W & rd_W!=0 & rd_W==rsN_E`.
  - Else 00.
  - MEM has priority over WB.
- `wait_cnt` (16 bit): increments each MEM_WAIT cycle and clears on exit. `mem_timeout` sets when `wait_cnt` reaches `MEM_TIMEOUT`. It stays set until reset, and the stall continues.
- Both 32-bit counters wrap from 0xFFFFFFFF to 0.

## Timing
- Stage-control outputs and `fwd*` are combinational from the current state and inputs (zero latency). Counters and `mem_timeout` update on the `clk` rising edge.
- While `rst_n`=0:
  - `flushD`..`flushW`=1, all bubbles 0, `fwd*`=00.
  - `stall_cycles`=0, `redirects`=0, `mem_timeout`=0, `lu_cnt`=0, `wait_cnt`=0.
  - FSM forced to RUN.
- Reset asserted mid-LU_STALL or mid-MEM_WAIT aborts immediately, with no completion.
- Load-use costs exactly `LOAD_USE_STALLS` cycles. Memory wait costs exactly the number of `dmem_ready_M`=0 cycles while `dmem_req_M`=1.

## Structure
- `hazard_pkg`: state enum (RUN, LU_STALL, MEM_WAIT) and forwarding-select constants (`FWD_RF`=00, `FWD_MEM`=01, `FWD_WB`=10).
- Sub-module `perf_cnt32`: 32-bit wrapping counter with async active-low clear and increment enable. Instantiated twice.

## Test plan
- Load-use: load x5 in EX, ID reads x5 via rs1, `LOAD_USE_STALLS`=1 -> one cycle `bubbleF`=`bubbleD`=`flushE`=1, then clear; `stall_cycles`=1. Repeat with 2 -> two cycles; `stall_cycles`=2. With rd_E=x0 -> no stall.
- Forwarding: `rd_M`=`rd_W`=x7, both writing, `rs1_E`=x7 -> `fwd1_E`=01. Drop `reg_write_M` -> 10. `rs2_E`=x0 -> `fwd2_E`=00.
- Memory wait: `dmem_req_M`=1, ready low 3 cycles -> `bubbleF`..`bubbleM`=1, `flushW`=1 for 3 cycles; `stall_cycles`=3.
- Wait plus branch: `br_taken_E`=1 during a 2-cycle wait -> no flushD/E during the wait; `flushD`=`flushE`=1 on the exit cycle; `redirects`=1.
- Timeout: `MEM_TIMEOUT`=4, ready held low 6 cycles -> `mem_timeout` rises after the 4th wait cycle and stays 1 after ready; clears only on `rst_n`=0.
- Reset mid-wait: assert `rst_n`=0 in MEM_WAIT -> all flushes 1 and counters 0 immediately. After release with no hazards, all stage controls are 0.
